// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, port owner
// encoding and the round-robin pick between fetch and data requesters.
package mem_port_arbiter_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // On a tie the port not served last wins.
   function automatic owner_t pick_owner(input logic fetch_req, input logic data_req,
                                         input owner_t last);
      owner_t pick;
      pick = OWN_I;
      if (fetch_req && data_req) begin
         pick = (last == OWN_D) ? OWN_I : OWN_D;
      end else if (data_req) begin
         pick = OWN_D;
      end
      return pick;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_wait.sv
// Saturating wait counter: counts stalled BUSY cycles and flags the last
// allowed one so the arbiter can abort a hung access.
module wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

   logic [7:0] count;

   assign expired = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory port between fetch and data
// requesters, one transaction at a time, with a hung-memory timeout.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 15
) (
   input  logic              real_clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [DATA_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [DATA_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              timeout
);

   state_t            state;
   owner_t            owner;
   owner_t            last_owner;
   owner_t            pick;
   logic              expired;
   logic              timer_clear;
   logic              timer_en;
   logic [DATA_W-1:0] capture;

   assign pick        = pick_owner(i_req, d_req, last_owner);
   assign timer_en    = (state == ST_BUSY);
   assign timer_clear = (state != ST_BUSY) || mem_ready;

   wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk     (real_clk),
      .rst_n   (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (expired)
   );

   // Writes and aborted accesses return zero instead of whatever is on the bus.
   always_comb begin
      capture = '0;
      if (mem_ready && !mem_we) begin
         capture = mem_rdata;
      end
   end

   always_ff @(posedge real_clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_I;
         last_owner <= OWN_D;
         i_gnt      <= 1'b0;
         i_valid    <= 1'b0;
         i_rdata    <= '0;
         d_gnt      <= 1'b0;
         d_valid    <= 1'b0;
         d_rdata    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         timeout    <= 1'b0;
      end else begin
         i_gnt   <= 1'b0;
         d_gnt   <= 1'b0;
         i_valid <= 1'b0;
         d_valid <= 1'b0;
         timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  owner  <= pick;
                  mem_en <= 1'b1;
                  state  <= ST_BUSY;
                  if (pick == OWN_I) begin
                     i_gnt     <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_addr  <= i_addr;
                     mem_wdata <= '0;
                  end else begin
                     d_gnt     <= 1'b1;
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end
               end
            end
            ST_BUSY: begin
               if (mem_ready || expired) begin
                  mem_en  <= 1'b0;
                  mem_we  <= 1'b0;
                  timeout <= !mem_ready;
                  state   <= ST_DONE;
                  if (owner == OWN_I) begin
                     i_valid <= 1'b1;
                     i_rdata <= capture;
                  end else begin
                     d_valid <= 1'b1;
                     d_rdata <= capture;
                  end
               end
            end
            ST_DONE: begin
               last_owner <= owner;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, zero-wait fetch, waited store,
// round-robin ties, timeout, mid-access reset and post-grant input changes.
module tb_mem_port_arbiter;

   logic        real_clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_valid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.DATA_W(32), .MAX_WAIT(15)) dut (
      .real_clk  (real_clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_valid   (i_valid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   initial real_clk = 1'b0;
   always #5 real_clk = ~real_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic tick();
      @(posedge real_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic exp_i;
      rst       = 1'b0;
      i_req     = 1'b0;
      i_addr    = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      tick();
      tick();

      chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_valid", {30'd0, i_valid, d_valid}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_mem_ctl", {29'd0, mem_en, mem_we, timeout}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b1;
      tick();

      // Zero-wait fetch; mem_ready stays high into IDLE where it must be ignored.
      i_req     = 1'b1;
      i_addr    = 32'h0040_0000;
      mem_ready = 1'b1;
      mem_rdata = 32'h2008_0005;
      tick();
      chk("t1_i_gnt", {31'd0, i_gnt}, 32'd1);
      chk("t1_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("t1_mem_en", {31'd0, mem_en}, 32'd1);
      chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
      chk("t1_mem_addr", mem_addr, 32'h0040_0000);
      tick();
      chk("t1_i_valid", {31'd0, i_valid}, 32'd1);
      chk("t1_i_rdata", i_rdata, 32'h2008_0005);
      chk("t1_mem_en_off", {31'd0, mem_en}, 32'd0);
      chk("t1_timeout", {31'd0, timeout}, 32'd0);
      chk("t1_i_gnt_off", {31'd0, i_gnt}, 32'd0);
      i_req = 1'b0;
      tick();
      chk("t1_i_valid_off", {31'd0, i_valid}, 32'd0);
      tick();
      chk("t1_idle_mem_en", {31'd0, mem_en}, 32'd0);
      mem_ready = 1'b0;

      // Store with three wait cycles.
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h1001_0004;
      d_wdata = 32'hDEAD_BEEF;
      tick();
      chk("t2_d_gnt", {31'd0, d_gnt}, 32'd1);
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) chk("t2_d_gnt_once", {31'd0, d_gnt}, 32'd0);
         chk("t2_mem_en", {31'd0, mem_en}, 32'd1);
         chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
         chk("t2_mem_addr", mem_addr, 32'h1001_0004);
         chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         chk("t2_no_valid", {31'd0, d_valid}, 32'd0);
         if (c == 4) mem_ready = 1'b1;
         tick();
      end
      chk("t2_d_valid", {31'd0, d_valid}, 32'd1);
      chk("t2_d_rdata", d_rdata, 32'd0);
      chk("t2_timeout", {31'd0, timeout}, 32'd0);
      chk("t2_mem_en_off", {31'd0, mem_en}, 32'd0);
      d_req     = 1'b0;
      d_we      = 1'b0;
      mem_ready = 1'b0;
      tick();
      chk("t2_d_valid_once", {31'd0, d_valid}, 32'd0);

      // Both requesting for four transactions: last served was data, so I,D,I,D.
      i_req     = 1'b1;
      d_req     = 1'b1;
      i_addr    = 32'h0040_0010;
      d_addr    = 32'h1001_0020;
      mem_ready = 1'b1;
      exp_i     = 1'b1;
      for (int n = 0; n < 4; n++) begin
         mem_rdata = 32'hA000_0000 + 32'(n);
         tick();
         chk("t3_i_gnt", {31'd0, i_gnt}, {31'd0, exp_i});
         chk("t3_d_gnt", {31'd0, d_gnt}, {31'd0, !exp_i});
         chk("t3_mem_addr", mem_addr, exp_i ? 32'h0040_0010 : 32'h1001_0020);
         tick();
         chk("t3_i_valid", {31'd0, i_valid}, {31'd0, exp_i});
         chk("t3_d_valid", {31'd0, d_valid}, {31'd0, !exp_i});
         chk("t3_rdata", exp_i ? i_rdata : d_rdata, 32'hA000_0000 + 32'(n));
         tick();
         chk("t3_gap_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
         if (n == 3) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
         exp_i = !exp_i;
      end
      tick();
      chk("t3_no_more_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);

      // Memory never answers: mem_en high for exactly 15 cycles, then abort.
      mem_ready = 1'b0;
      mem_rdata = 32'h5555_AAAA;
      i_req     = 1'b1;
      i_addr    = 32'h0040_0100;
      tick();
      chk("t4_i_gnt", {31'd0, i_gnt}, 32'd1);
      chk("t4_mem_en_1", {31'd0, mem_en}, 32'd1);
      for (int c = 2; c <= 15; c++) begin
         tick();
         chk("t4_mem_en_hold", {31'd0, mem_en}, 32'd1);
         chk("t4_no_valid", {31'd0, i_valid}, 32'd0);
      end
      tick();
      chk("t4_mem_en_off", {31'd0, mem_en}, 32'd0);
      chk("t4_i_valid", {31'd0, i_valid}, 32'd1);
      chk("t4_timeout", {31'd0, timeout}, 32'd1);
      chk("t4_i_rdata", i_rdata, 32'd0);
      i_req = 1'b0;
      tick();
      chk("t4_timeout_off", {31'd0, timeout}, 32'd0);

      // Next fetch after the abort completes normally.
      i_req     = 1'b1;
      i_addr    = 32'h0040_0104;
      mem_ready = 1'b1;
      mem_rdata = 32'h8C08_0000;
      tick();
      chk("t4b_i_gnt", {31'd0, i_gnt}, 32'd1);
      tick();
      chk("t4b_i_valid", {31'd0, i_valid}, 32'd1);
      chk("t4b_i_rdata", i_rdata, 32'h8C08_0000);
      chk("t4b_timeout", {31'd0, timeout}, 32'd0);
      i_req     = 1'b0;
      mem_ready = 1'b0;
      tick();

      // Reset in the second BUSY cycle of a data access.
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h1001_0040;
      tick();
      chk("t5_d_gnt", {31'd0, d_gnt}, 32'd1);
      tick();
      chk("t5_busy2_mem_en", {31'd0, mem_en}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_mem_en", {31'd0, mem_en}, 32'd0);
      tick();
      chk("t5_no_d_valid", {31'd0, d_valid}, 32'd0);
      chk("t5_rst_mem_en", {31'd0, mem_en}, 32'd0);
      rst       = 1'b1;
      i_req     = 1'b1;
      i_addr    = 32'h0040_0200;
      mem_ready = 1'b1;
      mem_rdata = 32'h1234_5678;
      tick();
      chk("t5_tie_i_gnt", {31'd0, i_gnt}, 32'd1);
      chk("t5_tie_d_gnt", {31'd0, d_gnt}, 32'd0);
      tick();
      chk("t5_i_valid", {31'd0, i_valid}, 32'd1);
      chk("t5_d_valid", {31'd0, d_valid}, 32'd0);
      chk("t5_i_rdata", i_rdata, 32'h1234_5678);
      i_req     = 1'b0;
      d_req     = 1'b0;
      mem_ready = 1'b0;
      tick();
      tick();

      // Address changes and req drops after grant: latched copy still used.
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h1001_0080;
      d_wdata = 32'h0BAD_F00D;
      tick();
      chk("t6_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("t6_mem_addr", mem_addr, 32'h1001_0080);
      d_req   = 1'b0;
      d_addr  = 32'h1001_0FF0;
      d_wdata = 32'hFFFF_FFFF;
      tick();
      chk("t6_mem_addr_kept", mem_addr, 32'h1001_0080);
      chk("t6_mem_we", {31'd0, mem_we}, 32'd0);
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE_0001;
      tick();
      chk("t6_d_valid", {31'd0, d_valid}, 32'd1);
      chk("t6_d_rdata", d_rdata, 32'hCAFE_0001);
      mem_ready = 1'b0;
      tick();
      tick();
      chk("t6_no_regrant", {30'd0, i_gnt, d_gnt}, 32'd0);
      chk("t6_idle_mem_en", {31'd0, mem_en}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
